// File: rtl/capture_pkg.sv
// Shared state encoding and length helpers for the capture sequencer.
package capture_pkg;

    localparam int unsigned MAX_LEN = 32768;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WAIT_TRIG,
        CAPTURE,
        READ_A,
        READ_B,
        DRAIN
    } cap_state_e;

    // A zero request still captures one sample; oversize requests saturate at the FIFO depth.
    function automatic int unsigned clamp_len(input logic [15:0] req, input int unsigned max_len);
        int unsigned r;
        r = 32'(req);
        if (r == 0) return 1;
        if (r > max_len) return max_len;
        return r;
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// In-flight {valid, chan} tracker matching the storage read latency.
module rd_valid_pipe #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in_valid,
    input  logic in_chan,
    output logic out_valid,
    output logic out_chan,
    output logic pending
);

    logic [RD_LAT-1:0][1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else if (clr) begin
            stage <= '0;
        end else begin
            stage[0] <= {in_valid, in_chan};
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // pending excludes the tail so the last word and done can share a cycle
    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
            pending = pending | stage[i][1];
        end
    end

    assign out_valid = stage[RD_LAT-1][1];
    assign out_chan  = stage[RD_LAT-1][0];

endmodule

// File: rtl/capture_sequencer.sv
// Flush / trigger / capture / dual-channel readout controller for the capture storage.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned FLUSH_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        abort,
    input  logic        trig,
    input  logic [15:0] sample_len,
    input  logic        chb_en,
    input  logic        host_ready,
    output logic        fifo_rst,
    output logic        load,
    output logic        rdenA,
    output logic        rdenB,
    output logic        word_valid,
    output logic        word_chan,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned FL_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int unsigned LEN_MAX = ((32'd1 << ADDR_W) < MAX_LEN) ? (32'd1 << ADDR_W) : MAX_LEN;

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic             chb_q, chb_d;
    logic             trig_q;
    logic             abort_q;
    logic             pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            flush_cnt_q <= '0;
            chb_q       <= 1'b0;
            trig_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            chb_q       <= chb_d;
            trig_q      <= trig;
            abort_q     <= abort;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chb_d       = chb_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        flush_cnt_d = flush_cnt_q;
        load        = 1'b0;
        rdenA       = 1'b0;
        rdenB       = 1'b0;
        done        = 1'b0;
        fifo_rst    = abort_q;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    len_d       = CNT_W'(clamp_len(sample_len, LEN_MAX));
                    chb_d       = chb_en;
                    flush_cnt_d = '0;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                fifo_rst = 1'b1;
                if (flush_cnt_q == FL_W'(FLUSH_CYC - 1)) begin
                    flush_cnt_d = '0;
                    state_d     = WAIT_TRIG;
                end else begin
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                end
            end
            WAIT_TRIG: begin
                if (trig && !trig_q) begin
                    wr_cnt_d = '0;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                load = 1'b1;
                if (wr_cnt_q == len_q - CNT_W'(1)) begin
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    state_d  = READ_A;
                end else begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end
            // The rd_cnt == len cycle issues no rden, giving the A->B mux its idle gap.
            READ_A, READ_B: begin
                if (rd_cnt_q < len_q) begin
                    if (host_ready) begin
                        rdenA    = (state_q == READ_A);
                        rdenB    = (state_q == READ_B);
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end else begin
                    rd_cnt_d = '0;
                    state_d  = (state_q == READ_A && chb_q) ? READ_B : DRAIN;
                end
            end
            DRAIN: begin
                if (!pend) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            done        = 1'b0;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            flush_cnt_d = '0;
        end
    end

    assign busy = (state_q != IDLE);

    rd_valid_pipe #(
        .RD_LAT(RD_LAT)
    ) u_valid_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort),
        .in_valid (rdenA | rdenB),
        .in_chan  (rdenB),
        .out_valid(word_valid),
        .out_chan (word_chan),
        .pending  (pend)
    );

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: table-driven acquisitions plus corner sequences.
module tb_capture_sequencer;

    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned FLUSH_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trig = 1'b0;
    logic [15:0] sample_len = '0;
    logic        chb_en = 1'b0;
    logic        host_ready = 1'b0;
    logic        fifo_rst, load, rdenA, rdenB, word_valid, word_chan, busy, done;

    always #5 clk = ~clk;

    capture_sequencer #(
        .ADDR_W   (15),
        .RD_LAT   (RD_LAT),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .abort     (abort),
        .trig      (trig),
        .sample_len(sample_len),
        .chb_en    (chb_en),
        .host_ready(host_ready),
        .fifo_rst  (fifo_rst),
        .load      (load),
        .rdenA     (rdenA),
        .rdenB     (rdenB),
        .word_valid(word_valid),
        .word_chan (word_chan),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // host_ready: constant 1, or the repeating 1,0,0,1 pattern
    logic       ready_toggle = 1'b0;
    logic [3:0] pat = 4'b1001;
    int unsigned ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) begin
                host_ready = pat[3 - ph];
                ph = (ph + 1) % 4;
            end else begin
                host_ready = 1'b1;
            end
        end
    end

    typedef struct {
        logic        chan;
        int unsigned due;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int          n_flush, n_load, n_load_rises, n_rda, n_rdb, n_words, n_done;
    int unsigned first_load_cyc;
    logic        prev_load = 1'b0;
    logic        prev_rda = 1'b0;

    task automatic clear_counters();
        n_flush = 0; n_load = 0; n_load_rises = 0; n_rda = 0; n_rdb = 0;
        n_words = 0; n_done = 0; first_load_cyc = 0;
    endtask

    // Monitor and scoreboard: every rden predicts one word RD_LAT cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_load = 1'b0;
            prev_rda  = 1'b0;
        end else begin
            if (fifo_rst) n_flush++;
            if (load) begin
                n_load++;
                if (!prev_load) begin
                    n_load_rises++;
                    if (first_load_cyc == 0) first_load_cyc = cyc;
                end
            end
            if (rdenA) n_rda++;
            if (rdenB) n_rdb++;
            if (rdenA || rdenB) check("rden_exclusive", 32'(rdenA & rdenB), 0);
            if (rdenB) check("ab_gap", 32'(prev_rda), 0);
            if (word_valid) begin
                n_words++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: word_valid at cycle %0d with no outstanding rden", cyc);
                end else begin
                    e = sb.pop_front();
                    check("word_chan", 32'(word_chan), 32'(e.chan));
                    check("word_latency", cyc, e.due);
                end
            end
            if (done) begin
                n_done++;
                check("done_with_word", 32'(word_valid), 1);
                check("done_sb_empty", sb.size(), 0);
            end
            if (abort) begin
                sb.delete();
            end else begin
                if (rdenA) sb.push_back('{chan: 1'b0, due: cyc + RD_LAT});
                if (rdenB) sb.push_back('{chan: 1'b1, due: cyc + RD_LAT});
            end
            prev_load = load;
            prev_rda  = rdenA;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_arm(input logic [15:0] len, input logic chb);
        sample_len = len;
        chb_en = chb;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        for (int unsigned i = 0; i < budget && n_done == 0; i++) tick();
        check({name, "_done_seen"}, n_done, 1);
    endtask

    typedef struct {
        logic [15:0] len;
        logic        chb;
        logic        tog;
        int unsigned exp_load;
        int unsigned exp_rda;
        int unsigned exp_rdb;
    } vec_t;

    vec_t vecs[5];
    int unsigned edge_cyc;
    int          words_at;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{len: 16'd4,     chb: 1'b1, tog: 1'b0, exp_load: 4,     exp_rda: 4,     exp_rdb: 4};
        vecs[1] = '{len: 16'd0,     chb: 1'b0, tog: 1'b0, exp_load: 1,     exp_rda: 1,     exp_rdb: 0};
        vecs[2] = '{len: 16'd6,     chb: 1'b0, tog: 1'b1, exp_load: 6,     exp_rda: 6,     exp_rdb: 0};
        vecs[3] = '{len: 16'd3,     chb: 1'b1, tog: 1'b1, exp_load: 3,     exp_rda: 3,     exp_rdb: 3};
        vecs[4] = '{len: 16'd40000, chb: 1'b0, tog: 1'b0, exp_load: 32768, exp_rda: 32768, exp_rdb: 0};
        clear_counters();

        #1;
        check("reset_outputs", 32'({fifo_rst, load, rdenA, rdenB, word_valid, word_chan, busy, done}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post_reset_busy", 32'(busy), 0);

        // Table-driven acquisitions
        for (int unsigned v = 0; v < 5; v++) begin
            clear_counters();
            ready_toggle = vecs[v].tog;
            pulse_arm(vecs[v].len, vecs[v].chb);
            repeat (FLUSH_CYC + 3) tick();
            trig = 1'b1;
            edge_cyc = cyc;
            tick();
            trig = 1'b0;
            wait_done("acq", 80000);
            repeat (RD_LAT + 3) tick();
            check("flush_cycles",   n_flush, FLUSH_CYC);
            check("load_cycles",    n_load, vecs[v].exp_load);
            check("load_contig",    n_load_rises, 1);
            check("load_start",     first_load_cyc, edge_cyc + 1);
            check("rdenA_cycles",   n_rda, vecs[v].exp_rda);
            check("rdenB_cycles",   n_rdb, vecs[v].exp_rdb);
            check("word_count",     n_words, vecs[v].exp_rda + vecs[v].exp_rdb);
            check("done_count",     n_done, 1);
            check("idle_after",     32'(busy), 0);
        end
        ready_toggle = 1'b0;

        // Trigger held high from before arm must not fire
        clear_counters();
        trig = 1'b1;
        tick();
        pulse_arm(16'd2, 1'b0);
        repeat (FLUSH_CYC + 10) tick();
        check("held_trig_no_load", n_load, 0);
        check("held_trig_busy", 32'(busy), 1);
        trig = 1'b0;
        tick();
        trig = 1'b1;
        edge_cyc = cyc;
        tick();
        trig = 1'b0;
        wait_done("held_trig", 200);
        check("held_trig_load", n_load, 2);
        check("held_trig_start", first_load_cyc, edge_cyc + 1);

        // Abort in READ_B with a simultaneous arm
        repeat (3) tick();
        clear_counters();
        pulse_arm(16'd8, 1'b1);
        repeat (FLUSH_CYC + 3) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int unsigned i = 0; i < 200 && !rdenB; i++) tick();
        check("reached_read_b", 32'(rdenB), 1);
        abort = 1'b1;
        arm = 1'b1;
        sample_len = 16'd5;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        words_at = n_words;
        check("abort_idle", 32'(busy), 0);
        check("abort_rden", 32'({rdenA, rdenB}), 0);
        check("abort_load", 32'(load), 0);
        check("abort_fifo_rst", 32'(fifo_rst), 1);
        tick();
        check("abort_fifo_rst_end", 32'(fifo_rst), 0);
        check("abort_arm_ignored", 32'(busy), 0);
        repeat (6) tick();
        check("abort_no_done", n_done, 0);
        check("abort_no_words", n_words, words_at);

        // Asynchronous reset in the middle of CAPTURE
        clear_counters();
        pulse_arm(16'd100, 1'b0);
        repeat (FLUSH_CYC + 3) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (10) tick();
        check("load_before_reset", 32'(load), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({fifo_rst, load, rdenA, rdenB, word_valid, word_chan, busy, done}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counters();
        repeat (5) tick();
        check("after_reset_busy", 32'(busy), 0);
        check("after_reset_load", n_load, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Single-clock controller that sequences the dual-channel capture storage through one acquisition: flush, wait for trigger, write a programmed number of samples, then stream channel A followed by channel B to the host interface.
- Drives the storage block's load, rst, rdenA and rdenB. Produces a host-side word-valid strobe aligned to the storage's registered dout.
- Sits between the host command/readout logic and the storage instance. Write and read clocks are tied to the same clk.

Parameters:
- ADDR_W, 15, log2 of per-channel FIFO depth (32768 words).
- RD_LAT, 2, cycles from a rdenA/rdenB assertion to valid data on storage dout.
- FLUSH_CYC, 8, cycles that fifo_rst is held high during flush.

Ports:
- clk  in  1  single system clock; drives storage wrclk and rdclk.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse that starts an acquisition.
- abort  in  1  one-cycle pulse that returns the block to IDLE from any state.
- trig  in  1  capture trigger; rising edge detected internally.
- sample_len  in  16  samples per channel; 0 is treated as 1, values above 32768 are clamped to 32768.
- chb_en  in  1  1 = read channel B after A; 0 = skip B. Sampled at arm.
- host_ready  in  1  host can accept words this cycle.
- fifo_rst  out  1  to storage rst.
- load  out  1  to storage load.
- rdenA  out  1  to storage rdenA.
- rdenB  out  1  to storage rdenB.
- word_valid  out  1  storage dout is valid this cycle.
- word_chan  out  1  0 = A, 1 = B; qualified by word_valid.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last word's word_valid is issued.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; all outputs 0; all counters 0; trig edge register = 0.
- States:
  - IDLE: on arm, latch the clamped sample_len as len and latch chb_en, then go to FLUSH.
  - FLUSH: fifo_rst = 1 for exactly FLUSH_CYC cycles, then go to WAIT_TRIG.
  - WAIT_TRIG: on the first cycle where trig = 1 and the registered trig = 0, go to CAPTURE. A trig held high through FLUSH does not fire; a fresh rising edge is required.
  - CAPTURE: load = 1 for exactly len consecutive cycles, starting the cycle after the edge. wr_cnt counts from 0 to len-1, then go to READ_A.
  - READ_A: rdenA = host_ready while rd_cnt < len. rd_cnt increments on each issued rden. At rd_cnt = len, go to READ_B if chb_en latched = 1, else go to DRAIN. rd_cnt is cleared on that transition.
  - READ_B: same as READ_A using rdenB, then go to DRAIN.
  - DRAIN: wait until the valid pipeline is empty, then pulse done and go to IDLE.
- rdenA and rdenB are never high in the same cycle, and never high in the cycle immediately after the A→B transition. This one-cycle gap prevents mixing in storage's registered mux.
- Valid pipeline: an RD_LAT-deep shift register of {valid, chan} loaded on each rden. word_valid and word_chan are its tail.
  - Host flow control has a skid of RD_LAT: deasserting host_ready stops new rden in the same cycle, but in-flight words still emerge. The host must absorb up to RD_LAT words.
- done coincides with the final word_valid when the pipeline tail empties in the DRAIN entry cycle. Otherwise done is pulsed on the last cycle of DRAIN, which is the cycle of the final word_valid.
- arm outside IDLE is ignored.
- abort in any state:
  - Next cycle: state = IDLE; load, rden, and the pipeline are cleared.
  - fifo_rst is pulsed for 1 cycle.
  - done is not pulsed.
- abort and arm in the same cycle: abort wins.
- Counters are ADDR_W+1 bits wide so that len = 32768 is representable. A count of exactly 32768 must not wrap.
- busy is combinational from state.

Decomposition:
- Shared package capture_pkg:
  - state encoding localparams: IDLE, FLUSH, WAIT_TRIG, CAPTURE, READ_A, READ_B, DRAIN;
  - MAX_LEN = 32768;
  - the clamp function for sample_len.
- One sub-module, rd_valid_pipe (parameter RD_LAT, 2-bit payload), holding the in-flight {valid, chan} shift register.
- All other logic lives in capture_sequencer.

Test Plan:
- Reset with rst_n low mid-CAPTURE → all outputs 0 asynchronously; after release busy = 0 and no load.
- arm, sample_len = 4, chb_en = 1, trig edge, host_ready = 1 → fifo_rst high 8 cycles; load high 4 cycles; rdenA 4 cycles; 1 idle cycle; rdenB 4 cycles; 8 word_valid with word_chan = 0,0,0,0,1,1,1,1; done on the 8th word.
- sample_len = 0 → load and rdenA each 1 cycle. sample_len = 40000 → load exactly 32768 cycles, counter does not wrap.
- host_ready toggling 1,0,0,1 repeatedly during READ_A, len = 6 → exactly 6 rdenA; word_valid trails each by RD_LAT = 2; no extra or lost words.
- trig held high from before arm → no CAPTURE until trig falls and rises again.
- abort in READ_B, with arm asserted in the same cycle → next cycle IDLE, rden = 0, fifo_rst pulsed 1 cycle, no done, arm ignored.
